// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns EX_DM load/store controls into a
// req/ack memory transaction, stalls the pipeline, and forwards writeback data.
module dm_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] read_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        access_err
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [7:0] cnt_r;
  logic       access_s;
  logic       misaligned_s;
  logic       last_cnt_s;
  logic       stall_s;
  logic [4:0] lat_rd_r;
  logic       lat_reg_write_r;
  logic       lat_mem_to_reg_r;
  logic       lat_load_r;

  // Decode of the incoming EX_DM command and the timeout compare
  always_comb begin
    access_s     = mem_read_in | mem_write_in;
    misaligned_s = (mem_addr_in[1:0] != 2'b00);
    last_cnt_s   = (cnt_r == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (access_s) begin
          if (misaligned_s) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_REQ;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (dm_ack || last_cnt_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Stall output; gated by reset so it drops without waiting for an edge
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      S_IDLE:  stall_s = access_s;
      S_REQ:   stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
    stall = stall_s & reset;
  end

  // Memory interface, latched command, counter and writeback outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r            <= 8'd0;
      dm_req           <= 1'b0;
      dm_we            <= 1'b0;
      dm_addr          <= 32'd0;
      dm_wdata         <= 32'd0;
      lat_rd_r         <= 5'd0;
      lat_reg_write_r  <= 1'b0;
      lat_mem_to_reg_r <= 1'b0;
      lat_load_r       <= 1'b0;
      read_data_out    <= 32'd0;
      rd_out           <= 5'd0;
      reg_write_out    <= 1'b0;
      mem_to_reg_out   <= 1'b0;
      access_err       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          read_data_out <= 32'd0;
          if (access_s) begin
            dm_addr          <= {mem_addr_in[31:2], 2'b00};
            dm_wdata         <= write_data_in;
            lat_rd_r         <= rd_in;
            lat_reg_write_r  <= reg_write_in;
            lat_mem_to_reg_r <= mem_to_reg_in;
            lat_load_r       <= mem_read_in & ~mem_write_in;
            cnt_r            <= 8'd0;
            if (misaligned_s) begin
              // No request: the DONE cycle presents the controls with the error
              rd_out         <= rd_in;
              reg_write_out  <= reg_write_in;
              mem_to_reg_out <= mem_to_reg_in;
              access_err     <= 1'b1;
            end else begin
              dm_req         <= 1'b1;
              dm_we          <= mem_write_in;
              rd_out         <= 5'd0;
              reg_write_out  <= 1'b0;
              mem_to_reg_out <= 1'b0;
              if (mem_read_in && mem_write_in) begin
                access_err <= 1'b1;
              end else begin
                access_err <= access_err;
              end
            end
          end else begin
            rd_out         <= rd_in;
            reg_write_out  <= reg_write_in;
            mem_to_reg_out <= mem_to_reg_in;
          end
        end
        S_REQ: begin
          if (dm_ack) begin
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            rd_out         <= lat_rd_r;
            reg_write_out  <= lat_reg_write_r;
            mem_to_reg_out <= lat_mem_to_reg_r;
            read_data_out  <= lat_load_r ? dm_rdata : 32'd0;
          end else if (last_cnt_s) begin
            // Abort: suppress the writeback so no stale value lands in the RF
            dm_req         <= 1'b0;
            dm_we          <= 1'b0;
            rd_out         <= lat_rd_r;
            reg_write_out  <= 1'b0;
            mem_to_reg_out <= lat_mem_to_reg_r;
            read_data_out  <= 32'd0;
            access_err     <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          rd_out         <= 5'd0;
          reg_write_out  <= 1'b0;
          mem_to_reg_out <= 1'b0;
          read_data_out  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomized scoreboard bench for dm_access_ctrl: the driver expands each
// instruction into expected per-cycle outputs from the latency rules.
module tb_dm_access_ctrl;
  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        mem_read_in, mem_write_in;
  logic [31:0] mem_addr_in, write_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_to_reg_in;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] read_data_out;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_to_reg_out, access_err;

  dm_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_addr_in(mem_addr_in), .write_data_in(write_data_in),
    .rd_in(rd_in), .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .read_data_out(read_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .access_err(access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd_cmd, wr_cmd;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    logic        rw, mtr, spur;
    int          delay;
  } instr_t;

  typedef struct {
    logic        stall, req, we;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        rw, mtr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;

  // Reference model state: what the previous instruction left on the WB outputs
  logic [4:0]  m_rd;
  logic        m_rw, m_mtr, m_err;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs each cycle against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (check_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall", 32'(stall), 32'(e.stall));
      chk("dm_req", 32'(dm_req), 32'(e.req));
      chk("rd_out", 32'(rd_out), 32'(e.rd));
      chk("reg_write_out", 32'(reg_write_out), 32'(e.rw));
      chk("mem_to_reg_out", 32'(mem_to_reg_out), 32'(e.mtr));
      chk("read_data_out", read_data_out, e.rdata);
      chk("access_err", 32'(access_err), 32'(e.err));
      if (e.req) begin
        chk("dm_we", 32'(dm_we), 32'(e.we));
        chk("dm_addr", dm_addr, e.addr);
        if (e.we) chk("dm_wdata", dm_wdata, e.wdata);
      end
    end
  end

  function automatic exp_t base_exp();
    exp_t e;
    e.stall = 1'b0; e.req = 1'b0; e.we = 1'b0;
    e.addr = 32'd0; e.wdata = 32'd0;
    e.rd = 5'd0; e.rw = 1'b0; e.mtr = 1'b0; e.rdata = 32'd0;
    e.err = m_err;
    return e;
  endfunction

  task automatic set_idle_inputs();
    mem_read_in = 1'b0; mem_write_in = 1'b0;
    mem_addr_in = 32'd0; write_data_in = 32'd0;
    rd_in = 5'd0; reg_write_in = 1'b0; mem_to_reg_in = 1'b0;
    dm_ack = 1'b0; dm_rdata = 32'd0;
  endtask

  // Called at a cycle start (just after a rising edge); returns at the next one
  task automatic issue(input instr_t t);
    exp_t e;
    bit   acc, wr, acked;
    int   r;
    acc = t.rd_cmd | t.wr_cmd;
    mem_read_in = t.rd_cmd; mem_write_in = t.wr_cmd;
    mem_addr_in = t.addr; write_data_in = t.wdata;
    rd_in = t.rd; reg_write_in = t.rw; mem_to_reg_in = t.mtr;
    dm_ack = t.spur; dm_rdata = $urandom;
    e = base_exp();
    e.stall = acc;
    e.rd = m_rd; e.rw = m_rw; e.mtr = m_mtr; e.rdata = m_data;
    exp_q.push_back(e);
    if (!acc) begin
      m_rd = t.rd; m_rw = t.rw; m_mtr = t.mtr; m_data = 32'd0;
    end else if (t.addr[1:0] != 2'b00) begin
      m_err = 1'b1;
      @(posedge clk); #1;
      dm_ack = t.spur;
      e = base_exp();
      e.rd = t.rd; e.rw = t.rw; e.mtr = t.mtr;
      exp_q.push_back(e);
      m_rd = 5'd0; m_rw = 1'b0; m_mtr = 1'b0; m_data = 32'd0;
    end else begin
      wr = t.wr_cmd;
      if (t.rd_cmd && t.wr_cmd) m_err = 1'b1;
      acked = (t.delay < TIMEOUT);
      r = acked ? t.delay + 1 : TIMEOUT;
      for (int i = 0; i < r; i++) begin
        @(posedge clk); #1;
        dm_ack = (i == t.delay);
        dm_rdata = (i == t.delay) ? t.rdata : $urandom;
        e = base_exp();
        e.stall = 1'b1; e.req = 1'b1; e.we = wr;
        e.addr = {t.addr[31:2], 2'b00}; e.wdata = t.wdata;
        exp_q.push_back(e);
      end
      if (!acked) m_err = 1'b1;
      @(posedge clk); #1;
      dm_ack = (t.delay == r);
      dm_rdata = $urandom;
      e = base_exp();
      e.rd = t.rd; e.rw = acked ? t.rw : 1'b0; e.mtr = t.mtr;
      e.rdata = (acked && !wr) ? t.rdata : 32'd0;
      exp_q.push_back(e);
      m_rd = 5'd0; m_rw = 1'b0; m_mtr = 1'b0; m_data = 32'd0;
    end
    @(posedge clk); #1;
    dm_ack = 1'b0;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    reset = 1'b0;
    set_idle_inputs();
    #1;
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst dm_req", 32'(dm_req), 32'd0);
    chk("rst dm_we", 32'(dm_we), 32'd0);
    chk("rst dm_addr", dm_addr, 32'd0);
    chk("rst dm_wdata", dm_wdata, 32'd0);
    chk("rst read_data_out", read_data_out, 32'd0);
    chk("rst rd_out", 32'(rd_out), 32'd0);
    chk("rst reg_write_out", 32'(reg_write_out), 32'd0);
    chk("rst mem_to_reg_out", 32'(mem_to_reg_out), 32'd0);
    chk("rst access_err", 32'(access_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_rd = 5'd0; m_rw = 1'b0; m_mtr = 1'b0; m_data = 32'd0; m_err = 1'b0;
    check_en = 1'b1;
  endtask

  function automatic instr_t mk(input logic rdc, input logic wrc, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [4:0] rd, input logic rw, input int delay);
    instr_t t;
    t.rd_cmd = rdc; t.wr_cmd = wrc; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    t.rd = rd; t.rw = rw; t.mtr = rdc; t.spur = 1'b0; t.delay = delay;
    return t;
  endfunction

  function automatic instr_t rnd_instr();
    instr_t t;
    int k, k2;
    k = int'($urandom_range(0, 99));
    t.rd_cmd = ((k >= 40) && (k < 65)) || (k >= 90);
    t.wr_cmd = (k >= 65);
    t.addr = $urandom;
    t.addr[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    t.wdata = $urandom; t.rdata = $urandom;
    t.rd = 5'($urandom_range(0, 31));
    t.rw = 1'($urandom_range(0, 1));
    t.mtr = 1'($urandom_range(0, 1));
    t.spur = 1'($urandom_range(0, 1));
    k2 = int'($urandom_range(0, 9));
    if (k2 < 8)       t.delay = int'($urandom_range(0, 5));
    else if (k2 == 8) t.delay = int'($urandom_range(13, 16));
    else              t.delay = 40;
    return t;
  endfunction

  initial begin
    instr_t t;
    do_reset();
    // Pass-through, then a load acked 2 cycles late, then a store acked at once
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 0));
    issue(mk(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5'd7, 1'b1, 2));
    issue(mk(1'b0, 1'b1, 32'h44, 32'h12345678, 32'h0, 5'd0, 1'b0, 0));
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3, 1'b1, 0));
    do_reset();
    issue(mk(1'b1, 1'b0, 32'h42, 32'h0, 32'h0, 5'd9, 1'b1, 0));
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd4, 1'b0, 0));
    do_reset();
    issue(mk(1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 32'h0, 5'd2, 1'b1, 1));
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b1, 0));
    do_reset();
    issue(mk(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 5'd6, 1'b1, 99));
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 0));
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 0));

    // Reset asserted in the third REQ cycle of a load
    do_reset();
    check_en = 1'b0;
    mem_read_in = 1'b1; mem_addr_in = 32'h40; rd_in = 5'd11; reg_write_in = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("pre-reset dm_req", 32'(dm_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("async dm_req", 32'(dm_req), 32'd0);
    chk("async stall", 32'(stall), 32'd0);
    set_idle_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    m_rd = 5'd0; m_rw = 1'b0; m_mtr = 1'b0; m_data = 32'd0; m_err = 1'b0;
    check_en = 1'b1;
    t = mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1, 0);
    t.spur = 1'b1;
    issue(t);
    issue(mk(1'b1, 1'b0, 32'h80, 32'h0, 32'h5A5A5A5A, 5'd13, 1'b1, 1));
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd14, 1'b0, 0));

    // Randomized traffic with periodic resets
    for (int n = 0; n < 160; n++) begin
      if ((n % 25) == 0) do_reset();
      issue(rnd_instr());
    end
    issue(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 0));
    @(posedge clk); #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
